// File: rtl/reg_file_pkg.sv
// Shared definitions for the register file and the destination-select logic
// that feeds it: default widths and the architecturally named registers.
package reg_file_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;   // $zero, hard-wired to 0
    localparam logic [4:0] REG_RA   = 5'd31;  // $ra, jal link target

endpackage

// File: rtl/reg_file_if.sv
// Register file access bus.
//   we/wa/wd       : write port (RegWrite, destination mux, MemtoReg mux)
//   ra1/ra2, rd1/rd2 : operand read ports (rs, rt)
//   dbg_ra/dbg_rd  : debug read port for the board display
// master = datapath side, slave = register file.
interface reg_file_if
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
);
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [ADDR_W-1:0] dbg_ra;
    logic [DATA_W-1:0] dbg_rd;

    modport master (
        output we, wa, wd, ra1, ra2, dbg_ra,
        input  rd1, rd2, dbg_rd
    );

    modport slave (
        input  we, wa, wd, ra1, ra2, dbg_ra,
        output rd1, rd2, dbg_rd
    );
endinterface

// File: rtl/reg_file_read_port.sv
// One combinational read port of the register file.
//   rst        : reset level, suppresses the bypass while asserted
//   regs       : flattened register contents, entry 0 is ignored
//   ra         : read address
//   we/wa/wd   : current write request, used only when BYPASS=1
//   rd         : read data (0 for address 0)
module reg_file_read_port
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter bit          BYPASS = 1'b1
) (
    input  logic                                   rst,
    input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]     regs,
    input  logic [ADDR_W-1:0]                      ra,
    input  logic                                   we,
    input  logic [ADDR_W-1:0]                      wa,
    input  logic [DATA_W-1:0]                      wd,
    output logic [DATA_W-1:0]                      rd
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    always_comb begin
        rd = '0;
        if (ra != ZERO_ADDR) begin
            // Forward a same-cycle write; the stored value is already being
            // cleared during reset, so the forward is blocked there too.
            if (BYPASS && !rst && we && (wa == ra)) begin
                rd = wd;
            end else begin
                rd = regs[ra];
            end
        end
    end

endmodule

// File: rtl/reg_file.sv
// 32 x DATA_W MIPS register file: two combinational operand read ports,
// one synchronous write port and a non-bypassed debug read port.
//   clk : rising-edge clock for the write port
//   rst : asynchronous active-high clear of all registers
//   bus : reg_file_if slave (write port, operand reads, debug read)
// Register 0 has no storage and always reads 0.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter bit          BYPASS = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    reg_file_if.slave  bus
);

    localparam int unsigned NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [1:NREG-1];
    logic [DATA_W-1:0] regs_d [1:NREG-1];
    logic [NREG-1:0][DATA_W-1:0] regs_view;

    // Address 0 never matches the loop range, so writes to $zero drop out.
    always_comb begin
        for (int unsigned i = 1; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
            if (bus.we && (bus.wa == ADDR_W'(i))) begin
                regs_d[i] = bus.wd;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 1; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 1; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    always_comb begin
        regs_view = '0;
        for (int unsigned i = 1; i < NREG; i++) begin
            regs_view[i] = regs_q[i];
        end
    end

    reg_file_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_port1 (
        .rst  (rst),
        .regs (regs_view),
        .ra   (bus.ra1),
        .we   (bus.we),
        .wa   (bus.wa),
        .wd   (bus.wd),
        .rd   (bus.rd1)
    );

    reg_file_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_port2 (
        .rst  (rst),
        .regs (regs_view),
        .ra   (bus.ra2),
        .we   (bus.we),
        .wa   (bus.wa),
        .wd   (bus.wd),
        .rd   (bus.rd2)
    );

    reg_file_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(1'b0)) u_port_dbg (
        .rst  (rst),
        .regs (regs_view),
        .ra   (bus.dbg_ra),
        .we   (bus.we),
        .wa   (bus.wa),
        .wd   (bus.wd),
        .rd   (bus.dbg_rd)
    );

endmodule

// File: doc/reg_file.md
# reg_file

Register file for the single-cycle/multi-cycle MIPS datapath. It sits directly downstream of the 5-bit write-destination mux that selects between rt and rd. It consumes that mux output as its write address and supplies the ALU operand paths. It holds 32 general registers of DATA_W bits, with two combinational read ports, one synchronous write port and a debug read port for the board display. Register $0 is hard-wired to zero.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; depth is 2**ADDR_W
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports

Ports:
- clk  input  1  sole clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high; clears every register
- we  input  1  write enable (RegWrite)
- wa  input  ADDR_W  write address, driven by the rt/rd destination mux
- wd  input  DATA_W  write data (MemtoReg mux output)
- ra1  input  ADDR_W  read address A (rs)
- ra2  input  ADDR_W  read address B (rt)
- rd1  output  DATA_W  read data A
- rd2  output  DATA_W  read data B
- dbg_ra  input  ADDR_W  debug read address (switches)
- dbg_rd  output  DATA_W  debug read data (7-segment display path)

## Operation
- Storage: registers 1..31, each DATA_W bits. No storage element exists for register 0.
- Write: at the rising edge of clk, when we=1, rst=0 and wa!=0, the addressed register takes wd. A write with wa=0 is silently discarded.
- Reads are combinational: rd1=reg[ra1], rd2=reg[ra2], dbg_rd=reg[dbg_ra]. Any read of address 0 returns 0.
- Bypass (BYPASS=1): if we=1, wa!=0 and wa==ra1, then rd1=wd in the same cycle, before the edge. The same rule applies to rd2. dbg_rd is never bypassed.
- With BYPASS=0, a read of the register being written returns the old value until after the edge.
- Both read ports may address the same register and return identical data.
- Reset: when rst is asserted, all registers clear to 0 immediately, without waiting for clk. While rst=1, writes are ignored even if we=1. After rst is deasserted, the first write takes effect at the next rising edge.
- Reset mid-write: if rst rises in the same cycle as a pending write, the write is lost and the register reads 0.

## Timing
- Reset values: rd1, rd2 and dbg_rd are all 0 while rst=1 with BYPASS=0. With BYPASS=1, rd1 and rd2 are also forced to 0 during reset.
- Write latency: 1 clock. Data written at edge N is visible on the non-bypassed read ports after edge N.
- Read latency: 0 cycles (combinational from address and stored state).
- Bypass path: combinational from we, wa and wd to rd1/rd2. It is fully contained in this cycle and drives no register.
- No handshake and no stall. The write is unconditional when we=1.

## Structure
- Shared package/header: REG_ZERO=5'd0 and REG_RA=5'd31, plus the DATA_W/ADDR_W defaults used by the datapath and the destination mux.
- One sub-module: reg_file_read_port. It is instantiated three times and implements address decode, zero-register masking and the optional bypass. The debug instance is tied to bypass-off.
- Storage is an array of 31 flops held in the top level, with a single always block for the async clear and the write.

## Test plan
- Reset: load several registers, assert rst mid-cycle with no clk edge -> rd1, rd2 and dbg_rd read 0 immediately for addresses 1..31.
- Basic write/read: we=1, wa=5'd8, wd=32'hDEADBEEF, one edge. Then ra1=8, ra2=8, dbg_ra=8 -> all three read 32'hDEADBEEF.
- Zero register: we=1, wa=0, wd=32'hFFFFFFFF, one edge. Then ra1=0 -> rd1=0. Also check that every other register is unchanged.
- Bypass: BYPASS=1, reg[9]=32'h1, same cycle we=1, wa=9, wd=32'h55 with ra1=9 -> rd1=32'h55 before the edge while dbg_rd (dbg_ra=9) still reads 32'h1. With BYPASS=0 -> rd1=32'h1 before the edge.
- Write during reset: rst=1, we=1, wa=3, wd=32'hA5A5A5A5, edge. Then release rst -> reg[3]=0. The next write of the same value succeeds after one edge.
- Full sweep: write reg[i]=i*32'h01010101 for i=1..31 on consecutive edges, then read all pairs (i, 32-i) -> exact values, with reg[0]=0.
